// File: rtl/gate_pkg.sv
// Shared types and helpers for the effect-chain noise gate.
// Contents:
//   gate_state_e - FSM state encoding (also exported on the debug port)
//   thr_lookup   - 16-bit threshold table indexed by the 3-bit level select
//   gain_unity   - unity gain value for a given number of gain fraction bits
package gate_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_e;

  // Thresholds are given on a 16-bit sample scale; wider datapaths shift them up.
  function automatic logic [15:0] thr_lookup(input logic [2:0] level);
    logic [15:0] thr;
    case (level)
      3'd0:    thr = 16'd0;
      3'd1:    thr = 16'd200;
      3'd2:    thr = 16'd500;
      3'd3:    thr = 16'd1000;
      3'd4:    thr = 16'd2500;
      3'd5:    thr = 16'd4500;
      3'd6:    thr = 16'd8000;
      default: thr = 16'd14000;
    endcase
    return thr;
  endfunction

  function automatic logic [63:0] gain_unity(input int gain_w);
    return 64'd1 << gain_w;
  endfunction

endpackage

// File: rtl/gate_envelope.sv
// Envelope follower for the noise gate: saturating magnitude followed by a
// first-order leaky integrator, env += (|x| - env) >>> ENV_SHIFT.
// Updates only on strobed samples.
// Ports:
//   i_clk, i_rst_n - clock, async active-low reset (env clears to 0)
//   valid          - sample strobe
//   data           - signed input sample
//   env            - unsigned envelope, DATA_W-1 bits
module gate_envelope
  import gate_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ENV_SHIFT = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] data,
  output logic        [DATA_W-2:0] env
);

  localparam int EW = DATA_W - 1;
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic        [EW-1:0]     mag;
  logic signed [DATA_W-1:0] diff;
  logic signed [DATA_W-1:0] step;

  always_comb begin
    // Most-negative input has no positive twin; clamp to full scale.
    if (data == MOST_NEG)       mag = {EW{1'b1}};
    else if (data[DATA_W-1])    mag = EW'(-data);
    else                        mag = data[EW-1:0];
    diff = $signed({1'b0, mag}) - $signed({1'b0, env});
    // Arithmetic shift floors toward -inf, so decay always reaches 0 exactly.
    step = diff >>> ENV_SHIFT;
  end

  // Result always lies between env and mag, so the modular add never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   env <= '0;
    else if (valid) env <= env + step[EW-1:0];
  end

endmodule

// File: rtl/effect_gate_fsm.sv
// Noise gate for the per-sample effects pipeline. An envelope follower feeds a
// five-state FSM (CLOSED/ATTACK/OPEN/HOLD/RELEASE) that steers a gain register
// through attack and release ramps; the sample is scaled by the gain and
// registered, so o_data/o_valid appear one clock after i_valid.
// Build option: define EFFECT_GATE_HYST_EN to close at 75% of the open
// threshold instead of at the open threshold itself.
// Ports:
//   i_clk, i_rst_n - clock, async active-low reset
//   i_valid        - one-cycle sample strobe
//   i_enable       - 1 = gate active, 0 = bypass
//   i_level        - threshold select 0..7 (0 never closes)
//   i_data         - signed sample in
//   o_data         - gated sample out, held between strobes
//   o_valid        - i_valid delayed one clock
//   o_gate_open    - state is ATTACK, OPEN or HOLD
//   o_state        - current FSM state (debug)
module effect_gate_fsm
  import gate_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int GAIN_W        = 16,
  parameter int ENV_SHIFT     = 7,
  parameter int ATTACK_SHIFT  = 5,
  parameter int RELEASE_SHIFT = 10,
  parameter int HOLD_SAMPLES  = 480
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic                     i_enable,
  input  logic [2:0]               i_level,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_gate_open,
  output logic [2:0]               o_state
);

  localparam int EW  = DATA_W - 1;
  localparam int HCW = $clog2(HOLD_SAMPLES + 1);
  localparam int PW  = DATA_W + GAIN_W + 2;
  localparam logic [GAIN_W:0] UNITY     = (GAIN_W+1)'(gain_unity(GAIN_W));
  localparam logic [HCW-1:0]  HOLD_LOAD = HCW'(HOLD_SAMPLES);

  gate_state_e       state_q, state_d;
  logic [GAIN_W:0]   gain_q, gain_d;
  logic [HCW-1:0]    hold_q, hold_d;
  logic [EW-1:0]     env, thr_open, thr_close;
  logic              above_open, below_close;
  logic [GAIN_W:0]   att_step, rel_step, gain_up, gain_dn;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] scaled;

  gate_envelope #(.DATA_W(DATA_W), .ENV_SHIFT(ENV_SHIFT)) u_env (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .valid   (i_valid),
    .data    (i_data),
    .env     (env)
  );

  assign thr_open = EW'(thr_lookup(i_level)) << (DATA_W - 16);
`ifdef EFFECT_GATE_HYST_EN
  assign thr_close = thr_open - (thr_open >> 2);
`else
  assign thr_close = thr_open;
`endif

  // Decisions use env as it stood before this sample is folded in.
  assign above_open  = (env >= thr_open);
  assign below_close = (env <  thr_close);

  // Ramp arithmetic; both ramps take at least one LSB per strobe so they finish.
  always_comb begin
    att_step = (UNITY - gain_q) >> ATTACK_SHIFT;
    if (att_step == '0) att_step = (GAIN_W+1)'(1);
    rel_step = gain_q >> RELEASE_SHIFT;
    if (rel_step == '0) rel_step = (GAIN_W+1)'(1);
    gain_up = (att_step >= (UNITY - gain_q)) ? UNITY : gain_q + att_step;
    gain_dn = (rel_step >= gain_q) ? '0 : gain_q - rel_step;
  end

  // Re-open checks sit ahead of expiry/completion so they win on a tie.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    hold_d  = hold_q;
    if (!i_enable) begin
      state_d = OPEN;
      gain_d  = UNITY;
      hold_d  = '0;
    end else begin
      case (state_q)
        CLOSED: begin
          gain_d = '0;
          if (above_open) state_d = ATTACK;
        end
        ATTACK: begin
          if (below_close) state_d = RELEASE;
          else begin
            gain_d = gain_up;
            if (gain_up == UNITY) state_d = OPEN;
          end
        end
        OPEN: begin
          gain_d = UNITY;
          if (below_close) begin
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        HOLD: begin
          gain_d = UNITY;
          if (above_open) state_d = OPEN;
          else if (hold_q <= HCW'(1)) begin
            state_d = RELEASE;
            hold_d  = '0;
          end else hold_d = hold_q - 1'b1;
        end
        RELEASE: begin
          if (above_open) state_d = ATTACK;
          else begin
            gain_d = gain_dn;
            if (gain_dn == '0) state_d = CLOSED;
          end
        end
        default: begin
          state_d = OPEN;
          gain_d  = UNITY;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Signed sample times zero-extended gain; unity gain shifts back to the input exactly.
  assign prod   = $signed({{(GAIN_W+2){i_data[DATA_W-1]}}, i_data}) *
                  $signed({{(DATA_W+1){1'b0}}, gain_q});
  assign scaled = DATA_W'(prod >>> GAIN_W);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= OPEN;
      gain_q  <= UNITY;
      hold_q  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        state_q <= state_d;
        gain_q  <= gain_d;
        hold_q  <= hold_d;
        o_data  <= i_enable ? scaled : i_data;
      end
    end
  end

  assign o_gate_open = (state_q == ATTACK) || (state_q == OPEN) || (state_q == HOLD);
  assign o_state     = state_q;

endmodule

// File: tb/tb_effect_gate_fsm.sv
// Directed bench for effect_gate_fsm: a vector table for bypass and level-0
// pass-through, plus hand sequences for hold length, release, attack, burst
// re-open, async reset and the hysteresis build option.
module tb_effect_gate_fsm;

  localparam logic [2:0] S_CLOSED = 3'd0, S_ATTACK = 3'd1, S_OPEN = 3'd2,
                         S_HOLD = 3'd3, S_RELEASE = 3'd4;

  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, enable = 1'b0;
  logic [2:0] level = 3'd0;
  logic signed [15:0] din = '0, dout;
  logic vout, gopen;
  logic [2:0] st;
  int errs = 0, checks = 0;

  typedef struct {
    logic       en;
    logic [2:0] lvl;
    int         d;
    int         exp_d;
    logic [2:0] exp_st;
    logic       exp_open;
  } vec_t;

  vec_t vt [10];
  int sine_tab [16];

  effect_gate_fsm dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_enable    (enable),
    .i_level     (level),
    .i_data      (din),
    .o_data      (dout),
    .o_valid     (vout),
    .o_gate_open (gopen),
    .o_state     (st)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Two clocks per strobe; on return (a negedge) outputs reflect this sample.
  task automatic strobe(input int d);
    @(negedge clk); valid = 1'b1; din = 16'(d);
    @(negedge clk); valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int prev;
    sine_tab = '{0, 3061, 5657, 7391, 8000, 7391, 5657, 3061,
                 0, -3061, -5657, -7391, -8000, -7391, -5657, -3061};
    vt[0] = '{1'b0, 3'd0, 1234,   1234,   S_OPEN, 1'b1};
    vt[1] = '{1'b0, 3'd0, -5,     -5,     S_OPEN, 1'b1};
    vt[2] = '{1'b0, 3'd0, -32768, -32768, S_OPEN, 1'b1};
    vt[3] = '{1'b0, 3'd0, 0,      0,      S_OPEN, 1'b1};
    vt[4] = '{1'b0, 3'd7, -7,     -7,     S_OPEN, 1'b1};
    vt[5] = '{1'b1, 3'd0, 100,    100,    S_OPEN, 1'b1};
    vt[6] = '{1'b1, 3'd0, -100,   -100,   S_OPEN, 1'b1};
    vt[7] = '{1'b1, 3'd0, -32768, -32768, S_OPEN, 1'b1};
    vt[8] = '{1'b1, 3'd0, 32767,  32767,  S_OPEN, 1'b1};
    vt[9] = '{1'b1, 3'd0, 55,     55,     S_OPEN, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_data", dout, 0);
    chk("rst_valid", vout, 0);
    chk("rst_open", gopen, 1);
    chk("rst_state", st, S_OPEN);
    @(negedge clk); rst_n = 1'b1;

    // Table: bypass then level-0 pass-through
    for (int i = 0; i < 10; i++) begin
      enable = vt[i].en; level = vt[i].lvl;
      strobe(vt[i].d);
      chk($sformatf("vec%0d_data", i), dout, vt[i].exp_d);
      chk($sformatf("vec%0d_valid", i), vout, 1);
      chk($sformatf("vec%0d_state", i), st, vt[i].exp_st);
      chk($sformatf("vec%0d_open", i), gopen, vt[i].exp_open);
    end
    // o_valid is a single cycle, o_data holds between strobes
    @(negedge clk);
    chk("valid_drop", vout, 0);
    chk("data_hold", dout, 55);

    // Level 3 sine then silence: OPEN -> HOLD(480) -> RELEASE -> CLOSED
    do_reset();
    enable = 1'b0; level = 3'd3;
    for (int i = 0; i < 512; i++) strobe(sine_tab[i % 16]);
    enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      strobe(sine_tab[i % 16]);
      chk("sine_state", st, S_OPEN);
      chk("sine_data", dout, sine_tab[i % 16]);
    end
    n = 0;
    while (st == S_OPEN && n < 1000) begin strobe(0); n++; end
    chk("open_to_hold", st, S_HOLD);
    n = 1;
    while (st == S_HOLD && n < 600) begin
      strobe(0);
      if (st == S_HOLD) n++;
    end
    chk("hold_strobes", n, 480);
    chk("hold_to_release", st, S_RELEASE);
    n = 1;
    while (st == S_RELEASE && n < 9000) begin
      strobe(0);
      if (st == S_RELEASE) n++;
    end
    chk("release_to_closed", st, S_CLOSED);
    chk("release_len_5000_7000", (n >= 5000 && n <= 7000), 1);
    strobe(500);
    chk("closed_data", dout, 0);
    chk("closed_open", gopen, 0);

    // Step to 8000 from CLOSED: ATTACK with monotonic gain, then OPEN
    n = 0;
    while (st == S_CLOSED && n < 100) begin
      strobe(8000); n++;
      chk("closed_mute", dout, 0);
    end
    chk("closed_to_attack", st, S_ATTACK);
    prev = 0; n = 0;
    while (st == S_ATTACK && n < 2000) begin
      strobe(8000); n++;
      chk("attack_open", gopen, 1);
      chk("attack_monotonic", (int'(dout) >= prev), 1);
      prev = dout;
    end
    chk("attack_to_open", st, S_OPEN);
    strobe(8000);
    chk("open_unity", dout, 8000);

    // Burst during RELEASE re-opens without dropping gain to 0
    n = 0;
    while (st != S_RELEASE && n < 1500) begin strobe(0); n++; end
    chk("reach_release", st, S_RELEASE);
    for (int i = 0; i < 60; i++) strobe(0);
    chk("still_release", st, S_RELEASE);
    n = 0;
    while (st == S_RELEASE && n < 100) begin strobe(8000); n++; end
    chk("burst_to_attack", st, S_ATTACK);
    chk("burst_gain_kept", (dout > 4000 && dout < 8000), 1);
    prev = dout;
    strobe(8000);
    chk("burst_ramp_up", (int'(dout) >= prev), 1);
    chk("burst_state", st, S_ATTACK);

    // Async reset mid-ramp clears immediately
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_state", st, S_OPEN);
    chk("async_data", dout, 0);
    chk("async_open", gopen, 1);
    @(negedge clk); rst_n = 1'b1;
    strobe(8000);
    chk("post_rst_unity", dout, 8000);
    chk("post_rst_hold", st, S_HOLD);

    // Envelope parked at 900 with level 3: hysteresis keeps OPEN
    do_reset();
    enable = 1'b0; level = 3'd3;
    for (int i = 0; i < 40; i++) strobe(32767);
    for (int i = 0; i < 1500; i++) strobe(900);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      strobe(900);
      chk("hyst_data", dout, 900);
`ifdef EFFECT_GATE_HYST_EN
      chk("hyst_state", st, S_OPEN);
`else
      chk("hyst_state", st, S_HOLD);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
